// File: rtl/serial_add_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : serial_add_pkg                                             |
// | Description : Shared types and defaults for the bit-serial adder         |
// |               sequencer: FSM state encoding, default geometry and the    |
// |               frame counter width helper.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package serial_add_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_SUM_LAT = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   // The frame counter spans shift plus drain cycles and must also hold the
   // value it steps to on the final drain cycle without wrapping.
   function automatic int cnt_width(input int width, input int sum_lat);
      return $clog2(width + sum_lat + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : serial_add_sequencer_if                                    |
// | Description : Parallel operand/result handshake of the serial adder      |
// |               sequencer.                                                 |
// |   master : producer/consumer side (drives in_*, out_ready)               |
// |   slave  : sequencer side (drives in_ready, out_*)                       |
// |   in_valid/in_ready/in_a/in_b/in_cin   operand word handshake            |
// |   out_valid/out_ready/out_sum/out_cout result word handshake             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface serial_add_sequencer_if #(
   parameter int WIDTH = serial_add_pkg::DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );

endinterface
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_shift_reg                                           |
// | Description : Right-shifting register with parallel load, serial input   |
// |               into the MSB and serial output from the LSB.               |
// |   clk, rst      clock, asynchronous active-high reset                    |
// |   i_load        parallel load (wins over shift)                          |
// |   i_load_val    parallel load value                                      |
// |   i_shift       shift right by one, i_ser_in enters at the MSB           |
// |   o_q           current contents                                         |
// |   o_q_next      contents after a shift this cycle                        |
// |   o_ser_out     current LSB                                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_shift_reg #(
   parameter int WIDTH = 8
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_load,
   input  wire  [WIDTH-1:0] i_load_val,
   input  wire              i_shift,
   input  wire              i_ser_in,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_q_next,
   output logic             o_ser_out
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;

   assign w_next    = {i_ser_in, r_q[WIDTH-1:1]};
   assign o_q       = r_q;
   assign o_q_next  = w_next;
   assign o_ser_out = r_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= w_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_add_sequencer                                       |
// | Description : Accepts a parallel operand word, clears the serial adder,  |
// |               streams A/B LSB-first (carry-in on bit 0 only), collects   |
// |               the delayed sum stream and final carry, and offers the     |
// |               parallel result through a valid/ready handshake.           |
// |   clk, reset        clock, asynchronous active-high reset                |
// |   bus (slave)       operand and result handshakes                        |
// |   sa_clr            one-cycle clear of the adder carry state             |
// |   sa_a/sa_b/sa_cin  serial operand bits / carry-in to the adder          |
// |   sa_sum/sa_cout    serial sum bit / carry-out from the adder            |
// |   busy              high whenever the FSM is not idle                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SUM_LAT = DEF_SUM_LAT
) (
   input  wire                   clk,
   input  wire                   reset,
   serial_add_sequencer_if.slave bus,
   output logic                  sa_clr,
   output logic                  sa_a,
   output logic                  sa_b,
   output logic                  sa_cin,
   input  wire                   sa_sum,
   input  wire                   sa_cout,
   output logic                  busy
);

   localparam int CNT_W = cnt_width(WIDTH, SUM_LAT);

   // Frame counter runs from 0 at shift cycle 0 through the last drain cycle.
   localparam logic [CNT_W-1:0] c_last_shift   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_last_drain   = CNT_W'(WIDTH + SUM_LAT - 1);
   localparam logic [CNT_W-1:0] c_first_sample = CNT_W'(SUM_LAT);

   seq_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cin;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_sum;
   logic             r_out_cout;
   logic             r_sa_clr;
   logic             r_sa_a;
   logic             r_sa_b;
   logic             r_sa_cin;
   logic             r_busy;

   logic               w_accept;
   logic               w_op_shift;
   logic               w_sum_shift;
   logic [2*WIDTH-1:0] w_op_q;
   logic [2*WIDTH-1:0] w_op_next;
   logic               w_op_ser;
   logic [WIDTH-1:0]   w_sum_q;
   logic [WIDTH-1:0]   w_sum_next;
   logic               w_sum_ser;
   logic               w_unused_bits;

   assign w_accept   = (r_state == IDLE) && bus.in_valid && r_in_ready;

   // Operands are packed {B, A}; after k shifts A[k] sits at bit 0 and B[k]
   // at bit WIDTH. The register advances on the edge that drives each bit.
   assign w_op_shift = (r_state == CLR) || (r_state == SHIFT);

   // Sum bit k arrives SUM_LAT cycles after its operand bits were driven.
   assign w_sum_shift = ((r_state == SHIFT) || (r_state == DRAIN)) &&
                        (r_cnt >= c_first_sample);

   serial_shift_reg #(
      .WIDTH (2 * WIDTH)
   ) u_op_sr (
      .clk        (clk),
      .rst        (reset),
      .i_load     (w_accept),
      .i_load_val ({bus.in_b, bus.in_a}),
      .i_shift    (w_op_shift),
      .i_ser_in   (1'b0),
      .o_q        (w_op_q),
      .o_q_next   (w_op_next),
      .o_ser_out  (w_op_ser)
   );

   serial_shift_reg #(
      .WIDTH (WIDTH)
   ) u_sum_sr (
      .clk        (clk),
      .rst        (reset),
      .i_load     (1'b0),
      .i_load_val ({WIDTH{1'b0}}),
      .i_shift    (w_sum_shift),
      .i_ser_in   (sa_sum),
      .o_q        (w_sum_q),
      .o_q_next   (w_sum_next),
      .o_ser_out  (w_sum_ser)
   );

   // Register taps not needed by this configuration.
   assign w_unused_bits = &{1'b0, w_op_q[2*WIDTH-1:WIDTH+1], w_op_q[WIDTH-1:0],
                            w_op_next, w_sum_q, w_sum_ser};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_cin       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_cout  <= 1'b0;
         r_sa_clr    <= 1'b0;
         r_sa_a      <= 1'b0;
         r_sa_b      <= 1'b0;
         r_sa_cin    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_sa_clr <= 1'b0;
         r_sa_a   <= 1'b0;
         r_sa_b   <= 1'b0;
         r_sa_cin <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cin      <= bus.in_cin;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_sa_clr   <= 1'b1;
                  r_state    <= CLR;
               end
            end
            CLR: begin
               r_cnt    <= '0;
               r_sa_a   <= w_op_ser;
               r_sa_b   <= w_op_q[WIDTH];
               r_sa_cin <= r_cin;
               r_state  <= SHIFT;
            end
            SHIFT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_shift) begin
                  r_state <= DRAIN;
               end else begin
                  r_sa_a <= w_op_ser;
                  r_sa_b <= w_op_q[WIDTH];
               end
            end
            DRAIN: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last_drain) begin
                  // The final sum bit is captured straight from the shifted
                  // value so the result is complete on entry to DONE.
                  r_out_sum   <= w_sum_next;
                  r_out_cout  <= sa_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_cout  = r_out_cout;
   assign sa_clr        = r_sa_clr;
   assign sa_a          = r_sa_a;
   assign sa_b          = r_sa_b;
   assign sa_cin        = r_sa_cin;
   assign busy          = r_busy;

endmodule
`default_nettype wire
